// File: rtl/data_memory_responder.sv
// Handshaked fixed-latency data-memory responder with word-addressed RAM.
// Optional: define DM_ALIGN_CHECK_EN to flag misaligned requests via Error.
module data_memory_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] ReadData,
  output logic        Error
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       wdata;
  logic              wr;
  logic              rd;
  logic              mis;
  logic              mis_in;
  logic              accept;
  logic              commit;
  logic [31:0]       mem [2**ADDR_W];

  assign ReqReady  = (state == IDLE);
  assign RespValid = (state == RESP);
  assign accept    = ReqValid && ReqReady;
  assign commit    = (state == WAIT) && (cnt == 4'd0);

`ifdef DM_ALIGN_CHECK_EN
  assign mis_in = |Address[1:0];
`else
  assign mis_in = 1'b0;
`endif

  // Upper address bits wrap; low bits only matter with the align check
  logic unused_addr;
  assign unused_addr = ^{Address[31:ADDR_W+2], Address[1:0]};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept)    state_n = WAIT;
      WAIT:    if (commit)    state_n = RESP;
      RESP:    if (RespReady) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt      <= 4'd0;
      idx      <= '0;
      wdata    <= 32'd0;
      wr       <= 1'b0;
      rd       <= 1'b0;
      mis      <= 1'b0;
      ReadData <= 32'd0;
      Error    <= 1'b0;
    end else begin
      if (accept) begin
        cnt   <= 4'(LATENCY - 1);
        idx   <= Address[ADDR_W+1:2];
        wdata <= WriteData;
        wr    <= MemWrite;
        rd    <= MemRead;
        mis   <= mis_in;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        ReadData <= (rd && !mis) ? mem[idx] : 32'd0;
        Error    <= mis;
      end
    end
  end

  // Read above sees the pre-write word on the same edge
  always_ff @(posedge Clock) begin
    if (commit && wr && !mis) mem[idx] <= wdata;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder.
// Honours DM_ALIGN_CHECK_EN when the same define is given to the bench.
module tb_data_memory_responder;

  localparam int AW  = 10;
  localparam int LAT = 2;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic [31:0] Address = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic        RespValid;
  logic        RespReady = 1'b0;
  logic [31:0] ReadData;
  logic        Error;

  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  logic [31:0] model [int];

  data_memory_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .RespValid (RespValid),
    .RespReady (RespReady),
    .ReadData  (ReadData),
    .Error     (Error)
  );

  always #5 Clock = ~Clock;

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  function automatic logic misal(input logic [31:0] a);
`ifdef DM_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Drive a request until accepted; returns with time #1 after accept edge
  task automatic accept(input logic [31:0] a, input logic [31:0] wd,
                        input logic w, input logic r, input bit track,
                        output bit ok);
    exp_t x;
    int   k;
    int   i;
    @(negedge Clock);
    Address = a; WriteData = wd; MemWrite = w; MemRead = r;
    ReqValid = 1'b1;
    k = 0;
    while (!ReqReady && k < 50) begin
      @(negedge Clock);
      k++;
    end
    ok = ReqReady;
    @(posedge Clock);
    #1;
    ReqValid = 1'b0;
    Address = $urandom; WriteData = $urandom;
    MemWrite = 1'b0; MemRead = 1'b0;
    if (ok && track) begin
      i = widx(a);
      if (!model.exists(i)) model[i] = 32'd0;
      x.e = misal(a);
      x.d = (r && !x.e) ? model[i] : 32'd0;
      if (w && !x.e) model[i] = wd;
      sb.push_back(x);
    end
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!RespValid && lat < 50) begin
      @(posedge Clock);
      #1;
      lat++;
    end
    if (!RespValid) lat = -1;
  endtask

  // Full transaction with immediate consume; returns observations
  task automatic xact(input logic [31:0] a, input logic [31:0] wd,
                      input logic w, input logic r,
                      output int lat, output logic [31:0] d,
                      output logic e, output exp_t x);
    bit ok;
    accept(a, wd, w, r, 1'b1, ok);
    if (!ok) lat = -2;
    else wait_resp(lat);
    d = ReadData;
    e = Error;
    x = sb.size() > 0 ? sb.pop_front() : '0;
    RespReady = 1'b1;
    @(posedge Clock);
    #1;
    RespReady = 1'b0;
  endtask

  task automatic test_reset;
    int          lat;
    logic [31:0] d;
    logic        e;
    exp_t        x;
    bit          ok;
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    n_checks++;
    if (RespValid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_respvalid got %b want 0", RespValid);
    end
    n_checks++;
    if (ReadData !== 32'd0 || Error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outs got %h/%b want 0/0", ReadData, Error);
    end
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    n_checks++;
    if (ReqReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_reqready got %b want 1", ReqReady);
    end
    xact(32'h40, 32'h0, 1'b1, 1'b0, lat, d, e, x);
    accept(32'h40, 32'h12345678, 1'b1, 1'b0, 1'b0, ok);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    #2;
    n_checks++;
    if (RespValid !== 1'b0 || !ok) begin
      n_fail++;
      $display("FAIL midwait_respvalid got %b want 0", RespValid);
    end
    repeat (3) @(posedge Clock);
    #1;
    n_checks++;
    if (RespValid !== 1'b0) begin
      n_fail++;
      $display("FAIL midwait_hold got %b want 0", RespValid);
    end
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    n_checks++;
    if (ReqReady !== 1'b1) begin
      n_fail++;
      $display("FAIL midwait_reqready got %b want 1", ReqReady);
    end
    xact(32'h40, 32'h0, 1'b0, 1'b1, lat, d, e, x);
    n_checks++;
    if (d !== x.d || d !== 32'h0) begin
      n_fail++;
      $display("FAIL midwait_read got %h want %h", d, x.d);
    end
  endtask

  task automatic test_basic;
    int          lat;
    logic [31:0] d;
    logic        e;
    exp_t        x;
    xact(32'h10, 32'hDEADBEEF, 1'b1, 1'b0, lat, d, e, x);
    n_checks++;
    if (lat !== LAT) begin
      n_fail++;
      $display("FAIL basic_wr_lat got %0d want %0d", lat, LAT);
    end
    xact(32'h10, 32'h0, 1'b0, 1'b1, lat, d, e, x);
    n_checks++;
    if (lat !== LAT) begin
      n_fail++;
      $display("FAIL basic_rd_lat got %0d want %0d", lat, LAT);
    end
    n_checks++;
    if (d !== x.d || e !== x.e) begin
      n_fail++;
      $display("FAIL basic_rd got %h/%b want %h/%b", d, e, x.d, x.e);
    end
  endtask

  task automatic test_backpressure;
    int   lat;
    bit   ok;
    bit   bad;
    exp_t x;
    accept(32'h10, 32'h0, 1'b0, 1'b1, 1'b1, ok);
    wait_resp(lat);
    x = sb.size() > 0 ? sb.pop_front() : '0;
    bad = !ok || lat != LAT;
    for (int c = 0; c < 5; c++) begin
      if (RespValid !== 1'b1 || ReadData !== x.d || ReqReady !== 1'b0)
        bad = 1'b1;
      @(posedge Clock);
      #1;
    end
    n_checks++;
    if (bad || ReadData !== x.d) begin
      n_fail++;
      $display("FAIL bp_hold got %b/%h/%b want 1/%h/0",
               RespValid, ReadData, ReqReady, x.d);
    end
    RespReady = 1'b1;
    @(posedge Clock);
    #1;
    RespReady = 1'b0;
    n_checks++;
    if (RespValid !== 1'b0 || ReqReady !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release got %b/%b want 0/1", RespValid, ReqReady);
    end
  endtask

  task automatic test_read_modify;
    int          lat;
    logic [31:0] d;
    logic        e;
    exp_t        x;
    xact(32'h10, 32'hCAFEF00D, 1'b1, 1'b1, lat, d, e, x);
    n_checks++;
    if (d !== x.d || d !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rmw_old got %h want %h", d, x.d);
    end
    xact(32'h10, 32'h0, 1'b0, 1'b1, lat, d, e, x);
    n_checks++;
    if (d !== x.d || d !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL rmw_new got %h want %h", d, x.d);
    end
  endtask

  task automatic test_wrap_noop;
    int          lat;
    logic [31:0] d;
    logic        e;
    exp_t        x;
    xact(32'h1000, 32'h55, 1'b1, 1'b0, lat, d, e, x);
    xact(32'h0, 32'h0, 1'b0, 1'b1, lat, d, e, x);
    n_checks++;
    if (d !== x.d || d !== 32'h55) begin
      n_fail++;
      $display("FAIL wrap got %h want 00000055", d);
    end
    xact(32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, d, e, x);
    n_checks++;
    if (lat !== LAT || d !== 32'h0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL noop got lat %0d data %h want %0d/0", lat, d, LAT);
    end
    xact(32'h0, 32'h0, 1'b0, 1'b1, lat, d, e, x);
    n_checks++;
    if (d !== 32'h55) begin
      n_fail++;
      $display("FAIL noop_nowrite got %h want 00000055", d);
    end
  endtask

  task automatic test_align;
    int          lat;
    logic [31:0] d;
    logic        e;
    exp_t        x;
    xact(32'h12, 32'h77, 1'b1, 1'b0, lat, d, e, x);
    n_checks++;
    if (e !== x.e || d !== x.d || lat !== LAT) begin
      n_fail++;
      $display("FAIL align_wr got %h/%b want %h/%b", d, e, x.d, x.e);
    end
    xact(32'h10, 32'h0, 1'b0, 1'b1, lat, d, e, x);
    n_checks++;
    if (d !== x.d || e !== 1'b0) begin
      n_fail++;
      $display("FAIL align_rd got %h/%b want %h/0", d, e, x.d);
    end
  endtask

  task automatic test_back_to_back;
    int          lat;
    logic [31:0] d;
    logic        e;
    exp_t        x;
    logic [31:0] a;
    for (int n = 0; n < 24; n++) begin
      a = {$urandom_range(0, 3), 2'b00, 6'h0} + 32'({$urandom_range(0, 7), 2'b00});
      xact(a, $urandom, 1'($urandom), 1'($urandom), lat, d, e, x);
      n_checks++;
      if (d !== x.d || e !== x.e || lat !== LAT) begin
        n_fail++;
        $display("FAIL b2b[%0d] got %h/%b/%0d want %h/%b/%0d",
                 n, d, e, lat, x.d, x.e, LAT);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_read_modify;
    test_wrap_noop;
    test_align;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
